// File: rtl/baud_pkg.sv
// Shared constants for the fractional baud generator: default widths,
// common 50 MHz divisor pairs at x16 oversampling, and the minimum divisor.
package baud_pkg;

  localparam int unsigned INT_WIDTH_DEF       = 16;
  localparam int unsigned FRAC_WIDTH_DEF      = 4;
  localparam int unsigned OVERSAMPLE_DEF      = 16;

  // 50 MHz / (baud * 16) expressed as integer + frac/16
  localparam int unsigned DIV_115200_X16_INT  = 27;
  localparam int unsigned DIV_115200_X16_FRAC = 2;
  localparam int unsigned DIV_9600_X16_INT    = 325;
  localparam int unsigned DIV_9600_X16_FRAC   = 8;

  localparam int unsigned MIN_DIV             = 2;

endpackage

// File: rtl/baud_gen_frac_divider.sv
// Fractional clock divider: counts active_int (or active_int+1 after an
// accumulator carry) clocks per period and flags the last cycle of each period.
module frac_divider
  import baud_pkg::*;
#(
  parameter int unsigned INT_WIDTH  = INT_WIDTH_DEF,
  parameter int unsigned FRAC_WIDTH = FRAC_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic [INT_WIDTH-1:0]  start_cnt,
  input  logic [INT_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  output logic                  period_end
);

  logic [INT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [INT_WIDTH-1:0]  eff_int, term;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic                  ext_q, ext_d;

  always_comb begin
    eff_int    = (div_int < INT_WIDTH'(MIN_DIV)) ? INT_WIDTH'(MIN_DIV) : div_int;
    term       = ext_q ? eff_int : eff_int - INT_WIDTH'(1);
    // start suppresses a coincident terminal count entirely
    period_end = enable && !start && (cnt_q >= term);
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ext_d      = ext_q;
    if (start) begin
      cnt_d = start_cnt;
      acc_d = '0;
      ext_d = 1'b0;
    end else if (period_end) begin
      cnt_d          = '0;
      {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, div_frac};
    end else if (enable) begin
      cnt_d = cnt_q + INT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      ext_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      ext_q <= ext_d;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: sample ticks from frac_divider, a phase counter
// producing bit ticks, and a shadowed divisor applied at safe points.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned INT_WIDTH    = INT_WIDTH_DEF,
  parameter int unsigned FRAC_WIDTH   = FRAC_WIDTH_DEF,
  parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int unsigned DEFAULT_INT  = DIV_115200_X16_INT,
  parameter int unsigned DEFAULT_FRAC = DIV_115200_X16_FRAC
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  cfg_load,
  input  logic [INT_WIDTH-1:0]  cfg_int,
  input  logic [FRAC_WIDTH-1:0] cfg_frac,
  output logic                  sample_tick,
  output logic                  baud_tick,
  output logic                  cfg_pending
);

  localparam int unsigned PW         = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PHASE_MID  = PW'(OVERSAMPLE / 2);

  logic [INT_WIDTH-1:0]  act_int_q, act_int_d, sh_int_q, sh_int_d;
  logic [FRAC_WIDTH-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
  logic                  pend_q, pend_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic                  stick_q, stick_d, btick_q, btick_d;
  logic                  period_end, apply;
  logic [INT_WIDTH-1:0]  nxt_int, clamp_int, start_cnt;

  frac_divider #(
    .INT_WIDTH  (INT_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_div (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .start      (start),
    .start_cnt  (start_cnt),
    .div_int    (act_int_q),
    .div_frac   (act_frac_q),
    .period_end (period_end)
  );

  always_comb begin
    apply      = pend_q && (period_end || start || !enable);
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    if (apply) begin
      act_int_d  = sh_int_q;
      act_frac_d = sh_frac_q;
      pend_d     = 1'b0;
    end
    // a load in the application cycle lands in the shadow and stays pending
    if (cfg_load) begin
      sh_int_d  = cfg_int;
      sh_frac_d = cfg_frac;
      pend_d    = 1'b1;
    end

    // with no phase counter, start centres the divide counter instead
    nxt_int   = pend_q ? sh_int_q : act_int_q;
    clamp_int = (nxt_int < INT_WIDTH'(MIN_DIV)) ? INT_WIDTH'(MIN_DIV) : nxt_int;
    start_cnt = (OVERSAMPLE == 1) ? (clamp_int >> 1) : '0;

    phase_d = phase_q;
    if (start) begin
      phase_d = PHASE_MID;
    end else if (period_end) begin
      phase_d = phase_q + PW'(1);
    end
    stick_d = period_end;
    btick_d = period_end && ((OVERSAMPLE == 1) || (phase_q == PHASE_LAST));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      act_int_q  <= INT_WIDTH'(DEFAULT_INT);
      act_frac_q <= FRAC_WIDTH'(DEFAULT_FRAC);
      sh_int_q   <= INT_WIDTH'(DEFAULT_INT);
      sh_frac_q  <= FRAC_WIDTH'(DEFAULT_FRAC);
      pend_q     <= 1'b0;
      phase_q    <= '0;
      stick_q    <= 1'b0;
      btick_q    <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      phase_q    <= phase_d;
      stick_q    <= stick_d;
      btick_q    <= btick_d;
    end
  end

  assign sample_tick = stick_q;
  assign baud_tick   = btick_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: period patterns, start alignment,
// config shadowing, enable hold, divisor clamp and mid-run reset.
module tb_baud_gen_frac;

  logic        clock = 1'b0;
  logic        reset_n, enable, start, cfg_load;
  logic [15:0] cfg_int;
  logic [3:0]  cfg_frac;
  logic        sample_tick, baud_tick, cfg_pending;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned stray    = 0;

  baud_gen_frac #(
    .INT_WIDTH    (16),
    .FRAC_WIDTH   (4),
    .OVERSAMPLE   (16),
    .DEFAULT_INT  (27),
    .DEFAULT_FRAC (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .start       (start),
    .cfg_load    (cfg_load),
    .cfg_int     (cfg_int),
    .cfg_frac    (cfg_frac),
    .sample_tick (sample_tick),
    .baud_tick   (baud_tick),
    .cfg_pending (cfg_pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic next_tick(output int unsigned gap);
    gap = 0;
    do begin
      @(negedge clock);
      gap++;
      if (baud_tick && !sample_tick) stray++;
    end while (!sample_tick && gap < 4000);
  endtask

  task automatic next_baud(output int unsigned gap, output int unsigned samples);
    gap     = 0;
    samples = 0;
    do begin
      @(negedge clock);
      gap++;
      if (sample_tick) samples++;
      if (baud_tick && !sample_tick) stray++;
    end while (!baud_tick && gap < 4000);
  endtask

  task automatic load_cfg(input int unsigned i, input int unsigned f);
    cfg_int  = 16'(i);
    cfg_frac = 4'(f);
    cfg_load = 1'b1;
    @(negedge clock);
    cfg_load = 1'b0;
  endtask

  initial begin
    int unsigned g, g2, s, total, bauds, ticks;
    reset_n  = 1'b0;
    enable   = 1'b1;
    start    = 1'b0;
    cfg_load = 1'b0;
    cfg_int  = '0;
    cfg_frac = '0;
    repeat (3) @(negedge clock);
    check("rst_sample", sample_tick, 0);
    check("rst_baud", baud_tick, 0);
    check("rst_pend", cfg_pending, 0);
    reset_n = 1'b1;

    // defaults 27/2: 28-clock period every 8th, 16 samples per bit
    next_tick(g);
    total = 0;
    bauds = 0;
    for (int i = 1; i <= 128; i++) begin
      next_tick(g);
      total += g;
      if (baud_tick) bauds++;
      if (i <= 16) check($sformatf("dflt_gap%0d", i), g, (i % 8 == 0) ? 28 : 27);
    end
    check("dflt_128_clocks", total, 3472);
    check("dflt_bauds", bauds, 8);

    // 4/0 then start: first bit tick after 8 x 4 clocks, then every 64
    load_cfg(4, 0);
    check("pend_set4", cfg_pending, 1);
    for (int i = 0; i < 100 && cfg_pending; i++) @(negedge clock);
    check("apply4", cfg_pending, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    next_baud(g, s);
    check("start_first_baud", g, 32);
    check("start_first_samples", s, 8);
    next_baud(g, s);
    check("baud_period64", g, 64);
    check("baud_samples16", s, 16);

    // 10/8 loaded mid-period: pending until next tick, then 10,10,11,10,11
    @(negedge clock);
    load_cfg(10, 8);
    check("pend_set10", cfg_pending, 1);
    next_tick(g);
    check("pend_clr10", cfg_pending, 0);
    for (int i = 1; i <= 5; i++) begin
      next_tick(g);
      check($sformatf("frac_gap%0d", i), g, (i == 3 || i == 5) ? 11 : 10);
    end

    // enable low 50 cycles inside a 10-clock period
    g     = 0;
    ticks = 0;
    repeat (3) begin
      @(negedge clock);
      g++;
      if (sample_tick) ticks++;
    end
    enable = 1'b0;
    repeat (50) begin
      @(negedge clock);
      g++;
      if (sample_tick || baud_tick) ticks++;
    end
    enable = 1'b1;
    next_tick(g2);
    check("hold_no_ticks", ticks, 0);
    check("hold_gap", g + g2, 60);

    // start on the terminal cycle of an 11-clock period
    repeat (10) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_tc_no_tick", sample_tick, 0);
    next_baud(g, s);
    check("start_tc_baud", g, 83);
    check("start_tc_samples", s, 8);

    // disabled: back-to-back loads, the second arriving on application
    enable = 1'b0;
    load_cfg(1, 0);
    load_cfg(0, 0);
    check("coinc_pend", cfg_pending, 1);
    @(negedge clock);
    check("dis_apply", cfg_pending, 0);
    enable = 1'b1;
    next_tick(g);
    for (int i = 1; i <= 3; i++) begin
      next_tick(g);
      check($sformatf("clamp0_gap%0d", i), g, 2);
    end
    load_cfg(1, 0);
    next_tick(g);
    next_tick(g);
    check("clamp1_gap", g, 2);

    // reset mid-run overrides start and cfg_load
    reset_n  = 1'b0;
    start    = 1'b1;
    cfg_int  = 16'd50;
    cfg_load = 1'b1;
    @(negedge clock);
    check("mrst_sample", sample_tick, 0);
    check("mrst_baud", baud_tick, 0);
    check("mrst_pend", cfg_pending, 0);
    reset_n  = 1'b1;
    start    = 1'b0;
    cfg_load = 1'b0;
    next_tick(g);
    next_tick(g);
    check("mrst_div27", g, 27);
    check("mrst_pend_after", cfg_pending, 0);

    check("stray_baud", stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 The block SHALL have parameter INT_WIDTH, default 16, integer-divisor width.
REQ-002 The block SHALL have parameter FRAC_WIDTH, default 4, fractional-divisor width (units of 1/2^FRAC_WIDTH clock).
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit, power of two, 1..64.
REQ-004 The block SHALL have parameter DEFAULT_INT, default 27, integer divisor loaded at reset (50 MHz, 115200 baud, x16).
REQ-005 The block SHALL have parameter DEFAULT_FRAC, default 2, fractional divisor loaded at reset.
REQ-006 The block SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset_n, input, 1, reset, synchronous and active-low.
REQ-008 The block SHALL have port enable, input, 1, run when 1; hold all counters when 0.
REQ-009 The block SHALL have port start, input, 1, one-cycle pulse realigning phase to mid-bit.
REQ-010 The block SHALL have port cfg_load, input, 1, one-cycle strobe capturing cfg_int/cfg_frac.
REQ-011 The block SHALL have port cfg_int, input, INT_WIDTH, new integer divisor.
REQ-012 The block SHALL have port cfg_frac, input, FRAC_WIDTH, new fractional divisor.
REQ-013 The block SHALL have port sample_tick, output, 1, registered one-cycle pulse per sample period.
REQ-014 The block SHALL have port baud_tick, output, 1, registered one-cycle pulse per bit period.
REQ-015 The block SHALL have port cfg_pending, output, 1, high while a loaded config awaits application.

Function
REQ-016 Sample period SHALL average active_int + active_frac/2^FRAC_WIDTH clocks; each individual period SHALL be active_int or active_int+1 clocks.
REQ-017 Fraction SHALL use a FRAC_WIDTH accumulator: at each sample-period end, acc <= acc + active_frac (wrap); carry-out makes the next period active_int+1.
REQ-018 active_int below 2 SHALL be treated as 2.
REQ-019 sample_tick SHALL assert for exactly one cycle, in the cycle after the divide counter reaches its terminal count; counter then restarts from 0.
REQ-020 A phase counter (log2 OVERSAMPLE bits, wrapping) SHALL advance on each sample period end; baud_tick SHALL assert in the same cycle as the sample_tick ending phase OVERSAMPLE-1.
REQ-021 With OVERSAMPLE==1, baud_tick SHALL equal sample_tick.
REQ-022 start SHALL clear divide counter and accumulator and load phase with OVERSAMPLE/2, so the first baud_tick follows OVERSAMPLE/2 full sample periods; with OVERSAMPLE==1 it SHALL load the divide counter with active_int/2 instead.
REQ-023 start SHALL take priority over a coincident terminal count; that terminal count SHALL produce no tick.
REQ-024 cfg_load SHALL copy cfg_int/cfg_frac into a shadow register and set cfg_pending the next cycle; a later cfg_load before application SHALL overwrite the shadow.
REQ-025 The shadow SHALL become active at the next sample-period end, on start, or immediately (next cycle) when enable==0; cfg_pending SHALL clear in that cycle.
REQ-026 cfg_load coincident with application SHALL win: new values go to shadow and cfg_pending stays 1.
REQ-027 With enable==0, counters, accumulator and phase SHALL hold, and both ticks SHALL be 0; start SHALL still act.
REQ-028 Ticks SHALL never assert in consecutive cycles unless active_int==2 (minimum period).

Reset
REQ-029 reset_n==0 at a clock edge SHALL set sample_tick=0, baud_tick=0, cfg_pending=0, counter=0, acc=0, phase=0, active divisor=DEFAULT_INT/DEFAULT_FRAC, shadow=defaults.
REQ-030 Reset SHALL override start, cfg_load and enable in the same cycle; mid-operation reset SHALL discard pending config.

Structure
REQ-031 Package baud_pkg SHALL hold default widths, DEFAULT_INT/DEFAULT_FRAC for 9600 and 115200 at x16, and the minimum-divisor constant 2.
REQ-032 One sub-module frac_divider (counter + accumulator + clamp, output period_end) SHALL be instantiated; phase, config shadow and start logic stay in the top level.

Verification
REQ-033 Reset, enable=1, defaults 27/2: sample_tick gaps SHALL be 27 clocks with a 28 every 8th period; 16 sample ticks per baud_tick; 128 samples = 3472 clocks.
REQ-034 cfg_int=4, cfg_frac=0, OVERSAMPLE=16, start pulse: first baud_tick exactly 8x4 clocks after start; then every 64 clocks.
REQ-035 cfg_load 10/8 mid-period: cfg_pending=1 until next sample_tick; subsequent periods alternate 10,11.
REQ-036 enable=0 for 50 cycles mid-period: no ticks; resuming completes the remaining count without loss.
REQ-037 start and terminal count in same cycle: no tick that cycle; phase=OVERSAMPLE/2.
REQ-038 cfg_int=0 or 1: sample_tick every 2 clocks; reset_n low mid-run returns all outputs to 0 and divisor to 27/2.
